// File: rtl/maquina_temporizador.sv
// Phase countdown timer plus level-sensor debouncer feeding the washing-machine controller.
// Optional macro TEMP_CHEIO_GATE_EN: phases 0/1 only count while the tank reads full (cheio=1).
module maquina_temporizador #(
    parameter int CNT_W      = 8,
    parameter int T_LAVAR    = 5,
    parameter int T_ENXAGUAR = 4,
    parameter int T_SECAR    = 3,
    parameter int T_ESCORRER = 2,
    parameter int PRESCALE   = 1,
    parameter int DEB_CICLOS = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fase_inicio,
    input  logic [1:0]       fase_sel,
    input  logic             pausa,
    input  logic             cancelar,
    input  logic             sensor_nivel,
    output logic             cheio,
    output logic             tempo,
    output logic             ocupado,
    output logic [CNT_W-1:0] restante
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(DEB_CICLOS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CICLOS - 1);

    typedef enum logic [1:0] {OCIOSO, CONTANDO, PAUSADO, FIM} estado_t;

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] restante_q, restante_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tempo_q, tempo_d;
    logic             ocupado_q, ocupado_d;
    logic             sync1_q, sync2_q;
    logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
    logic             cheio_q, cheio_d;
    logic [CNT_W-1:0] t_sel;
    logic             inicio;
    logic             hold_tick;

    always_comb begin
        case (fase_sel)
            2'd0:    t_sel = CNT_W'(T_LAVAR);
            2'd1:    t_sel = CNT_W'(T_ENXAGUAR);
            2'd2:    t_sel = CNT_W'(T_SECAR);
            default: t_sel = CNT_W'(T_ESCORRER);
        endcase
    end

    // A start is only honoured when no phase is running and no cancel is pending.
    assign inicio = !cancelar && fase_inicio && (estado_q == OCIOSO || estado_q == FIM);

`ifdef TEMP_CHEIO_GATE_EN
    logic [1:0] fase_q, fase_d;

    assign fase_d    = inicio ? fase_sel : fase_q;
    assign hold_tick = !fase_q[1] && !cheio_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) fase_q <= 2'd0;
        else       fase_q <= fase_d;
    end
`else
    assign hold_tick = 1'b0;
`endif

    always_comb begin
        estado_d   = estado_q;
        restante_d = restante_q;
        presc_d    = presc_q;
        tempo_d    = tempo_q;
        if (cancelar) begin
            estado_d   = OCIOSO;
            restante_d = '0;
            presc_d    = '0;
            tempo_d    = 1'b0;
        end else if (inicio) begin
            presc_d = '0;
            if (t_sel == '0) begin
                estado_d   = FIM;
                restante_d = '0;
                tempo_d    = 1'b1;
            end else begin
                estado_d   = CONTANDO;
                restante_d = t_sel;
                tempo_d    = 1'b0;
            end
        end else if (estado_q == CONTANDO || estado_q == PAUSADO) begin
            if (pausa) begin
                estado_d = PAUSADO;
            end else begin
                // Releasing pause counts on the same edge, so each paused cycle delays by one.
                estado_d = CONTANDO;
                if (!hold_tick) begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d    = '0;
                        restante_d = restante_q - 1'b1;
                        if (restante_q == CNT_W'(1)) begin
                            estado_d = FIM;
                            tempo_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
        end
        ocupado_d = (estado_d == CONTANDO) || (estado_d == PAUSADO);
    end

    always_comb begin
        cheio_d   = cheio_q;
        deb_cnt_d = '0;
        if (sync2_q != cheio_q) begin
            if (deb_cnt_q == DEB_LAST) cheio_d   = ~cheio_q;
            else                       deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            restante_q <= '0;
            presc_q    <= '0;
            tempo_q    <= 1'b0;
            ocupado_q  <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_cnt_q  <= '0;
            cheio_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            restante_q <= restante_d;
            presc_q    <= presc_d;
            tempo_q    <= tempo_d;
            ocupado_q  <= ocupado_d;
            sync1_q    <= sensor_nivel;
            sync2_q    <= sync1_q;
            deb_cnt_q  <= deb_cnt_d;
            cheio_q    <= cheio_d;
        end
    end

    assign cheio    = cheio_q;
    assign tempo    = tempo_q;
    assign ocupado  = ocupado_q;
    assign restante = restante_q;

endmodule

// File: tb/tb_maquina_temporizador.sv
// Random-stimulus scoreboard bench: two timer instances (default and an alternate
// parameter set with a zero-length phase and PRESCALE=3) checked against a cycle model.
module tb_maquina_temporizador;

    logic       clock = 1'b0;
    logic       reset;
    logic       fase_inicio;
    logic [1:0] fase_sel;
    logic       pausa;
    logic       cancelar;
    logic       sensor_nivel;

    logic       cheio_a, tempo_a, ocupado_a;
    logic [7:0] restante_a;
    logic       cheio_b, tempo_b, ocupado_b;
    logic [7:0] restante_b;

    always #5 clock = ~clock;

    maquina_temporizador dut (
        .clock(clock), .reset(reset), .fase_inicio(fase_inicio), .fase_sel(fase_sel),
        .pausa(pausa), .cancelar(cancelar), .sensor_nivel(sensor_nivel),
        .cheio(cheio_a), .tempo(tempo_a), .ocupado(ocupado_a), .restante(restante_a)
    );

    maquina_temporizador #(
        .T_LAVAR(3), .T_ENXAGUAR(0), .T_SECAR(7), .T_ESCORRER(1),
        .PRESCALE(3), .DEB_CICLOS(1)
    ) dut_b (
        .clock(clock), .reset(reset), .fase_inicio(fase_inicio), .fase_sel(fase_sel),
        .pausa(pausa), .cancelar(cancelar), .sensor_nivel(sensor_nivel),
        .cheio(cheio_b), .tempo(tempo_b), .ocupado(ocupado_b), .restante(restante_b)
    );

    typedef struct {
        logic [1:0]      ch;
        logic [1:0]      tp;
        logic [1:0]      oc;
        logic [1:0][7:0] rs;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: per instance, whether a phase is running, whether it finished,
    // ticks left, cycles spent inside the current tick, and the debounce run length.
    bit m_act[2], m_done[2], m_cheio[2];
    int m_rem[2], m_sub[2], m_run[2], m_ph[2];
    bit h1, h2;

    function automatic int tval(int i, int s);
        if (i == 0) return (s == 0) ? 5 : (s == 1) ? 4 : (s == 2) ? 3 : 2;
        return (s == 0) ? 3 : (s == 1) ? 0 : (s == 2) ? 7 : 1;
    endfunction

    function automatic int pscale(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int debn(int i);
        return (i == 0) ? 3 : 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        bit   syn, gate;
        int   t;
        if (reset) begin
            h1 = 0; h2 = 0;
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 0; m_done[i] = 0; m_cheio[i] = 0;
                m_rem[i] = 0; m_sub[i] = 0; m_run[i] = 0; m_ph[i] = 0;
            end
        end else begin
            syn = h2; h2 = h1; h1 = sensor_nivel;
            for (int i = 0; i < 2; i++) begin
                gate = 0;
`ifdef TEMP_CHEIO_GATE_EN
                gate = (m_ph[i] < 2) && !m_cheio[i];
`endif
                if (cancelar) begin
                    m_act[i] = 0; m_done[i] = 0; m_rem[i] = 0; m_sub[i] = 0;
                end else if (!m_act[i] && fase_inicio) begin
                    t = tval(i, int'(fase_sel));
                    m_ph[i] = int'(fase_sel);
                    m_sub[i] = 0;
                    m_rem[i] = t;
                    m_act[i] = (t != 0);
                    m_done[i] = (t == 0);
                end else if (m_act[i] && !pausa && !gate) begin
                    m_sub[i]++;
                    if (m_sub[i] == pscale(i)) begin
                        m_sub[i] = 0;
                        m_rem[i]--;
                        if (m_rem[i] == 0) begin
                            m_act[i] = 0; m_done[i] = 1;
                        end
                    end
                end
                if (syn != m_cheio[i]) begin
                    m_run[i]++;
                    if (m_run[i] == debn(i)) begin
                        m_cheio[i] = !m_cheio[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            e.ch[i] = m_cheio[i];
            e.tp[i] = m_done[i];
            e.oc[i] = m_act[i];
            e.rs[i] = 8'(m_rem[i]);
        end
        q.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cheio"},   int'(cheio_a),   0);
        chk({tag, "_tempo"},   int'(tempo_a),   0);
        chk({tag, "_ocupado"}, int'(ocupado_a), 0);
        chk({tag, "_restante"}, int'(restante_a), 0);
        chk({tag, "_b_tempo"}, int'(tempo_b),   0);
        chk({tag, "_b_restante"}, int'(restante_b), 0);
    endtask

    // Monitor: DUT outputs are settled mid-cycle; compare against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("a_cheio",    int'(cheio_a),    int'(e.ch[0]));
            chk("a_tempo",    int'(tempo_a),    int'(e.tp[0]));
            chk("a_ocupado",  int'(ocupado_a),  int'(e.oc[0]));
            chk("a_restante", int'(restante_a), int'(e.rs[0]));
            chk("b_cheio",    int'(cheio_b),    int'(e.ch[1]));
            chk("b_tempo",    int'(tempo_b),    int'(e.tp[1]));
            chk("b_ocupado",  int'(ocupado_b),  int'(e.oc[1]));
            chk("b_restante", int'(restante_b), int'(e.rs[1]));
        end
    end

    initial begin
        bit prev_rst;
        reset = 1'b1; fase_inicio = 1'b0; fase_sel = 2'd0;
        pausa = 1'b0; cancelar = 1'b0; sensor_nivel = 1'b0;
        #1;
        chk_zero("reset_t0");
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clock);
            model_step();
            @(negedge clock);
            #1;
            prev_rst = reset;
            if (cyc < 3) reset = 1'b1;
            else         reset = ($urandom_range(199) < 2);
            fase_inicio = ($urandom_range(99) < 30);
            fase_sel    = 2'($urandom_range(3));
            pausa       = ($urandom_range(99) < 20);
            cancelar    = ($urandom_range(99) < 3);
            if ($urandom_range(99) < 15) sensor_nivel = !sensor_nivel;
            // A fresh reset must clear the outputs before any clock edge arrives.
            if (reset && !prev_rst) begin
                #1;
                chk_zero("async_reset");
            end
        end
        @(negedge clock);
        #2;
        if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
